mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the processor's single-port data/instruction memory. It shares the memory between the processor (instruction fetch, stack push/pop, load/store) and the program loader (preloads code and data and inspects results). Round-robin arbitration. Each transaction is issued, waited out over a fixed memory latency, and acknowledged with a one-cycle done pulse. It sits between the datapath/loader and the memory array, at the same level as controller and datapath.

## Interface
- AW, 5: address width (words)
- DW, 8: data width
- MEM_LAT, 2: memory read latency in cycles; legal range 1..7
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- p_req  in  1  processor request; held until p_done
- p_we  in  1  processor write (1) / read (0)
- p_addr  in  AW  processor address
- p_wdata  in  DW  processor write data
- p_gnt  out  1  processor owns memory (ISSUE..DONE)
- p_done  out  1  one-cycle completion pulse
- p_rdata  out  DW  read data; valid when p_done=1
- l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  loader request bundle, same rules as processor
- l_gnt, l_done, l_rdata  out  1/1/DW  loader response bundle
- m_en  out  1  memory access strobe, one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after the m_en cycle

## Operation
- FSM states:
  - IDLE: no grant. Samples both requests. Any request -> ISSUE.
  - ISSUE: one cycle. m_en=1. m_we/m_addr/m_wdata come from the bundle latched at the IDLE->ISSUE edge. -> WAIT.
  - WAIT: exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1. On the last WAIT cycle, m_rdata is captured into the rdata register (reads only; writes leave the register unchanged). -> DONE.
  - DONE: one cycle. Winner's done=1. -> IDLE, unconditionally.
- Arbitration happens in IDLE only.
  - Only one requester: it wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer updates on the IDLE->ISSUE edge.
- A requester must hold all request inputs stable until its done. Inputs are latched at grant, so later changes do not affect the transaction in flight.
- Dropping req mid-transaction does not abort it. The transaction completes, and done still pulses.
- Req still high in the cycle after done is treated as a new request. This gives a minimum 1-cycle gap (IDLE) between transactions.
- p_rdata and l_rdata both drive the shared rdata register. Each is valid only with its own done.
- m_we, m_addr and m_wdata hold the latched values from ISSUE through DONE. They return to 0 in IDLE.
- Fairness: with both ports requesting continuously, grants strictly alternate.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE
  - all outputs 0 (gnt, done, m_en, m_we, m_addr, m_wdata, rdata)
  - counter=0
  - last-grant pointer=loader, so the processor wins the first tie
- Reset asserted mid-transaction aborts it: m_en and gnt drop immediately, and no done is produced.
- Let req be sampled high at the end of cycle R.
  - ISSUE (gnt=1, m_en=1): cycle R+1
  - WAIT: cycles R+2 .. R+1+MEM_LAT
  - DONE: cycle R+MEM_LAT+2
  - IDLE: cycle R+MEM_LAT+3
- Latency from req to done is MEM_LAT+2 cycles. This holds for reads and writes alike.
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- gnt is high from ISSUE through DONE inclusive.
- Requests arriving during a transaction are ignored until IDLE.
- A request arriving in the same cycle that DONE ends is seen in the following IDLE. It is issued one cycle after that IDLE.

## Test plan
All scenarios use AW=5, DW=8, MEM_LAT=2.
- Reset: hold rst=0 for 3 cycles, with p_req=1 during reset -> all outputs 0. After release, the first ISSUE is for the processor.
- Single write then read (loader): write 0x5A to address 0x1F, then read 0x1F.
  - Each l_done arrives 4 cycles after its req sample.
  - Memory model returns 0x5A -> l_rdata=0x5A during the read's l_done.
- Simultaneous requests: both req high from reset release.
  - Grant order: processor, loader, processor, loader.
  - Each grant is held 4 cycles (ISSUE..DONE).
  - Grants are separated by one IDLE cycle.
- Request dropped mid-transaction: p_req falls during WAIT -> p_done still pulses in the expected cycle. Next grant follows normal arbitration.
- Input change after grant: p_addr switches 0x03->0x07 during WAIT -> m_addr stays 0x03 through DONE.
- Reset mid-WAIT: rst pulses low in WAIT.
  - m_en, gnt and done are 0 immediately, and no done is produced.
  - After release with l_req=1, the loader is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port memory between the
// processor and the program loader; one transaction at a time, fixed latency.
module mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2   // legal range 1..7 (fits the 3-bit wait counter)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_done,
  output logic [DW-1:0] p_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_l_q, last_l_d;   // 1 = loader was granted last
  logic          own_l_q, own_l_d;     // 1 = loader owns the transaction in flight
  logic          p_gnt_q, p_gnt_d;
  logic          l_gnt_q, l_gnt_d;
  logic          p_done_q, p_done_d;
  logic          l_done_q, l_done_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick_l;

  // Next-state and registered-output logic for the sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_l_d  = last_l_q;
    own_l_d   = own_l_q;
    p_gnt_d   = p_gnt_q;
    l_gnt_d   = l_gnt_q;
    p_done_d  = 1'b0;
    l_done_d  = 1'b0;
    m_en_d    = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    // Loader wins if alone, or on a tie when the processor was served last
    pick_l    = l_req & (~p_req | ~last_l_q);

    case (state_q)
      S_IDLE: begin
        if (p_req || l_req) begin
          state_d   = S_ISSUE;
          own_l_d   = pick_l;
          last_l_d  = pick_l;
          p_gnt_d   = ~pick_l;
          l_gnt_d   = pick_l;
          m_en_d    = 1'b1;
          m_we_d    = pick_l ? l_we    : p_we;
          m_addr_d  = pick_l ? l_addr  : p_addr;
          m_wdata_d = pick_l ? l_wdata : p_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d  = S_DONE;
          p_done_d = ~own_l_q;
          l_done_d = own_l_q;
          if (!m_we_q) begin
            rdata_d = m_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        p_gnt_d   = 1'b0;
        l_gnt_d   = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = {AW{1'b0}};
        m_wdata_d = {DW{1'b0}};
      end
      default: begin
        state_d   = S_IDLE;
        p_gnt_d   = 1'b0;
        l_gnt_d   = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = {AW{1'b0}};
        m_wdata_d = {DW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      last_l_q  <= 1'b1;
      own_l_q   <= 1'b0;
      p_gnt_q   <= 1'b0;
      l_gnt_q   <= 1'b0;
      p_done_q  <= 1'b0;
      l_done_q  <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= {AW{1'b0}};
      m_wdata_q <= {DW{1'b0}};
      rdata_q   <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_l_q  <= last_l_d;
      own_l_q   <= own_l_d;
      p_gnt_q   <= p_gnt_d;
      l_gnt_q   <= l_gnt_d;
      p_done_q  <= p_done_d;
      l_done_q  <= l_done_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign p_gnt   = p_gnt_q;
  assign l_gnt   = l_gnt_q;
  assign p_done  = p_done_q;
  assign l_done  = l_done_q;
  assign p_rdata = rdata_q;
  assign l_rdata = rdata_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction table plus hand-written corner sequences,
// with a scoreboard checked by a monitor on the falling clock edge.
module tb_mem_arbiter;
  localparam int AW = 5, DW = 8, MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic p_req, p_we, l_req, l_we;
  logic [AW-1:0] p_addr, l_addr;
  logic [DW-1:0] p_wdata, l_wdata;
  logic p_gnt, p_done, l_gnt, l_done;
  logic [DW-1:0] p_rdata, l_rdata;
  logic m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  typedef struct {
    logic       is_l;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } xact_t;

  xact_t sb[$];
  xact_t vec[10];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int issue_cyc = 0;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_pipe [MEM_LAT];

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_done(p_done), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on strobe, read data delayed MEM_LAT cycles
  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    mem[3] <= 8'h33;
    mem[5] <= 8'h66;
    mem[6] <= 8'h77;
    mem[7] <= 8'hE7;
  end

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    rd_pipe[0] <= mem[m_addr];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[MEM_LAT-1];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: issue fields and done responses against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (m_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", 64'(m_en), 64'd0);
        end else begin
          chk("issue_gnt", {p_gnt, l_gnt}, sb[0].is_l ? 2'b01 : 2'b10);
          chk("issue_we", 64'(m_we), 64'(sb[0].we));
          chk("issue_addr", 64'(m_addr), 64'(sb[0].addr));
          chk("issue_wdata", 64'(m_wdata), 64'(sb[0].wdata));
          issue_cyc <= cyc;
        end
      end
      if (p_done || l_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {p_done, l_done}, 2'b00);
        end else begin
          chk("done_port", {p_done, l_done}, sb[0].is_l ? 2'b01 : 2'b10);
          chk("done_rdata", 64'(sb[0].is_l ? l_rdata : p_rdata), 64'(sb[0].rdata));
          chk("done_gnt", 64'(sb[0].is_l ? l_gnt : p_gnt), 64'd1);
          chk("issue_to_done", 64'(cyc - issue_cyc), 64'(MEM_LAT + 1));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic is_l, input logic req, input logic we,
                       input logic [4:0] addr, input logic [7:0] wdata);
    if (is_l) begin
      l_req = req; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      p_req = req; p_we = we; p_addr = addr; p_wdata = wdata;
    end
  endtask

  task automatic wait_done(input logic is_l, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(is_l ? l_done : p_done) && n < 20);
    chk("done_seen", 64'(is_l ? l_done : p_done), 64'd1);
  endtask

  task automatic xact(input xact_t t);
    int n;
    sb.push_back(t);
    @(posedge clk); #1;
    drive(t.is_l, 1'b1, t.we, t.addr, t.wdata);
    wait_done(t.is_l, n);
    chk("req_to_done", 64'(n), 64'(MEM_LAT + 2));
    drive(t.is_l, 1'b0, 1'b0, 5'h00, 8'h00);
  endtask

  initial begin
    int n;
    vec[0] = '{1'b1, 1'b1, 5'h1F, 8'h5A, 8'h77};
    vec[1] = '{1'b1, 1'b0, 5'h1F, 8'h00, 8'h5A};
    vec[2] = '{1'b0, 1'b1, 5'h00, 8'hA5, 8'h5A};
    vec[3] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'hA5};
    vec[4] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'hA5};
    vec[5] = '{1'b0, 1'b1, 5'h1F, 8'hFF, 8'hA5};
    vec[6] = '{1'b0, 1'b0, 5'h1F, 8'h00, 8'hFF};
    vec[7] = '{1'b1, 1'b1, 5'h10, 8'h3C, 8'hFF};
    vec[8] = '{1'b0, 1'b0, 5'h10, 8'h00, 8'h3C};
    vec[9] = '{1'b1, 1'b0, 5'h1F, 8'h00, 8'hFF};

    // Reset with both requesters already asking
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 5'h05, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 5'h06, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_ctl", {p_gnt, l_gnt, p_done, l_done, m_en, m_we}, 6'd0);
      chk("reset_data", {m_addr, m_wdata, p_rdata, l_rdata}, 29'd0);
    end
    sb.push_back('{1'b0, 1'b0, 5'h05, 8'h00, 8'h66});
    sb.push_back('{1'b1, 1'b0, 5'h06, 8'h00, 8'h77});
    sb.push_back('{1'b0, 1'b0, 5'h05, 8'h00, 8'h66});
    sb.push_back('{1'b1, 1'b0, 5'h06, 8'h00, 8'h77});
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic exp_p, exp_l;
      @(posedge clk); #1;
      exp_p = ((k % 5) < 4) && ((k / 5) % 2 == 0);
      exp_l = ((k % 5) < 4) && ((k / 5) % 2 == 1);
      chk("alt_gnt", {p_gnt, l_gnt}, {exp_p, exp_l});
      if ((k % 5) == 4) chk("idle_bus", {m_en, m_we, m_addr, m_wdata}, 15'd0);
      if (k == 16) begin
        p_req = 1'b0;
        l_req = 1'b0;
      end
    end

    for (int i = 0; i < 10; i++) xact(vec[i]);

    // Processor drops its request during WAIT
    sb.push_back('{1'b0, 1'b0, 5'h1F, 8'h00, 8'hFF});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 5'h1F, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    p_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drop_done", 64'(p_done), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("drop_no_regrant", {p_gnt, l_gnt, m_en}, 3'd0);
    end
    // Tie after a processor grant goes to the loader, then the processor
    sb.push_back('{1'b1, 1'b0, 5'h06, 8'h00, 8'h77});
    sb.push_back('{1'b0, 1'b0, 5'h05, 8'h00, 8'h66});
    drive(1'b1, 1'b1, 1'b0, 5'h06, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 5'h05, 8'h00);
    wait_done(1'b1, n);
    chk("tie_l_first", 64'(n), 64'(MEM_LAT + 2));
    l_req = 1'b0;
    wait_done(1'b0, n);
    chk("tie_p_next", 64'(n), 64'(MEM_LAT + 3));
    p_req = 1'b0;

    // Address change after grant must not reach the memory bus
    sb.push_back('{1'b0, 1'b0, 5'h03, 8'h00, 8'h33});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 5'h03, 8'h00);
    @(posedge clk); #1;
    chk("hold_addr_issue", 64'(m_addr), 64'h03);
    @(posedge clk); #1;
    p_addr = 5'h07;
    chk("hold_addr_wait1", 64'(m_addr), 64'h03);
    @(posedge clk); #1;
    chk("hold_addr_wait2", 64'(m_addr), 64'h03);
    @(posedge clk); #1;
    chk("hold_addr_done", {m_addr, p_done}, {5'h03, 1'b1});
    p_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_addr", 64'(m_addr), 64'h00);

    // Reset pulse in WAIT aborts the loader transaction
    sb.push_back('{1'b1, 1'b0, 5'h06, 8'h00, 8'h77});
    drive(1'b1, 1'b1, 1'b0, 5'h06, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    sb.delete();
    #1 chk("abort_now", {m_en, l_gnt, l_done, p_gnt, p_done}, 5'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_quiet", {m_en, l_gnt, l_done, p_gnt, p_done}, 5'd0);
    end
    sb.push_back('{1'b1, 1'b0, 5'h06, 8'h00, 8'h77});
    rst = 1'b1;
    wait_done(1'b1, n);
    chk("after_abort", 64'(n), 64'(MEM_LAT + 2));
    l_req = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
